encoder_position_tracker: RTL and testbench

Downstream consumer of the quadrature decoder's per-cycle direction code. It integrates direction steps into a signed, saturating position register and measures velocity as the net step count over a fixed sampling window. It also flags illegal direction codes. Position and velocity feed the motor-control and display logic.

---
 rtl/encoder_position_tracker.sv | 160 ++++++++++++++++
 tb/tb_encoder_position_tracker.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder_position_tracker.sv
// encoder_position_tracker
//
// Integrates the quadrature decoder's per-cycle step code into a signed,
// saturating position register, measures velocity as the net step count
// over a fixed window of WINDOW clock cycles, and flags illegal step codes.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   dir        step code: 01 = +1, 10 = -1, 00 = idle, 11 = illegal
//   clear      zero position and the error flag
//   load       preset position from load_val (clamped to the legal range)
//   load_val   signed preset value
//   position   signed accumulated position
//   at_min     position == POS_MIN
//   at_max     position == POS_MAX
//   velocity   signed net steps in the last completed window (saturated)
//   vel_valid  one-cycle pulse when velocity updates
//   dir_err    sticky flag, set by an illegal step code
module encoder_position_tracker #(
  parameter int WIDTH     = 16,
  parameter int POS_MIN   = -32768,
  parameter int POS_MAX   = 32767,
  parameter int VEL_WIDTH = 8,
  parameter int WINDOW    = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [1:0]                  dir,
  input  logic                        clear,
  input  logic                        load,
  input  logic signed [WIDTH-1:0]     load_val,
  output logic signed [WIDTH-1:0]     position,
  output logic                        at_min,
  output logic                        at_max,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        vel_valid,
  output logic                        dir_err
);

  localparam int CNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  // One extra bit beyond the velocity range so the accumulator can exceed
  // the output range before the final saturation.
  localparam int ACC_W = VEL_WIDTH + 1;

  localparam logic signed [WIDTH-1:0] POS_MIN_W = WIDTH'(POS_MIN);
  localparam logic signed [WIDTH-1:0] POS_MAX_W = WIDTH'(POS_MAX);
  localparam logic [CNT_W-1:0]        CNT_LAST  = CNT_W'(WINDOW - 1);

  // Limits expressed in the ACC_W+1 bit sum width so comparisons never overflow.
  localparam logic signed [ACC_W:0] ACC_MAX_X = (ACC_W+1)'(2**(ACC_W-1) - 1);
  localparam logic signed [ACC_W:0] ACC_MIN_X = (ACC_W+1)'(-(2**(ACC_W-1)));
  localparam logic signed [ACC_W:0] VEL_MAX_X = (ACC_W+1)'(2**(VEL_WIDTH-1) - 1);
  localparam logic signed [ACC_W:0] VEL_MIN_X = (ACC_W+1)'(-(2**(VEL_WIDTH-1)));

  logic signed [WIDTH-1:0]     position_reg;
  logic signed [VEL_WIDTH-1:0] velocity_reg;
  logic                        vel_valid_reg;
  logic                        dir_err_reg;
  logic [CNT_W-1:0]            cnt_reg;
  logic signed [ACC_W-1:0]     acc_reg;

  logic                        step_up;
  logic                        step_dn;
  logic                        illegal;
  logic                        window_end;
  logic signed [ACC_W:0]       step_delta;
  logic signed [ACC_W:0]       acc_sum;
  logic signed [ACC_W-1:0]     acc_next;
  logic signed [VEL_WIDTH-1:0] vel_next;
  logic signed [WIDTH-1:0]     load_clamped;

  assign step_up    = (dir == 2'b01);
  assign step_dn    = (dir == 2'b10);
  assign illegal    = (dir == 2'b11);
  assign window_end = (cnt_reg == CNT_LAST);

  always_comb begin
    step_delta = '0;
    if (step_up) begin
      step_delta = (ACC_W+1)'(1);
    end else if (step_dn) begin
      step_delta = '1;
    end

    // Sum includes the current cycle's step, so the window-closing sample
    // is counted in the velocity it closes.
    acc_sum = $signed({acc_reg[ACC_W-1], acc_reg}) + step_delta;

    acc_next = acc_sum[ACC_W-1:0];
    if (acc_sum > ACC_MAX_X) begin
      acc_next = ACC_MAX_X[ACC_W-1:0];
    end else if (acc_sum < ACC_MIN_X) begin
      acc_next = ACC_MIN_X[ACC_W-1:0];
    end

    vel_next = acc_sum[VEL_WIDTH-1:0];
    if (acc_sum > VEL_MAX_X) begin
      vel_next = VEL_MAX_X[VEL_WIDTH-1:0];
    end else if (acc_sum < VEL_MIN_X) begin
      vel_next = VEL_MIN_X[VEL_WIDTH-1:0];
    end

    load_clamped = load_val;
    if (load_val > POS_MAX_W) begin
      load_clamped = POS_MAX_W;
    end else if (load_val < POS_MIN_W) begin
      load_clamped = POS_MIN_W;
    end
  end

  // Position and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      position_reg <= '0;
      dir_err_reg  <= 1'b0;
    end else if (clear) begin
      position_reg <= '0;
      dir_err_reg  <= 1'b0;
    end else begin
      if (illegal) begin
        dir_err_reg <= 1'b1;
      end
      if (load) begin
        position_reg <= load_clamped;
      end else if (step_up && (position_reg < POS_MAX_W)) begin
        position_reg <= position_reg + WIDTH'(1);
      end else if (step_dn && (position_reg > POS_MIN_W)) begin
        position_reg <= position_reg - WIDTH'(1);
      end
    end
  end

  // Velocity window: independent of clear/load and of position saturation
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      velocity_reg  <= '0;
      vel_valid_reg <= 1'b0;
    end else if (window_end) begin
      cnt_reg       <= '0;
      acc_reg       <= '0;
      velocity_reg  <= vel_next;
      vel_valid_reg <= 1'b1;
    end else begin
      cnt_reg       <= cnt_reg + CNT_W'(1);
      acc_reg       <= acc_next;
      vel_valid_reg <= 1'b0;
    end
  end

  assign position  = position_reg;
  assign at_min    = (position_reg == POS_MIN_W);
  assign at_max    = (position_reg == POS_MAX_W);
  assign velocity  = velocity_reg;
  assign vel_valid = vel_valid_reg;
  assign dir_err   = dir_err_reg;

endmodule

// File: tb/tb_encoder_position_tracker.sv
// Testbench for encoder_position_tracker.
// u_a: 16-bit position, WINDOW=10 (position table, short velocity windows)
// u_b: 17-bit position with 16-bit bounds, WINDOW=256 (load clamp, velocity saturation)
module tb_encoder_position_tracker;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [1:0]         dir = 2'b00;
  logic               clear = 1'b0;
  logic               load = 1'b0;
  logic signed [15:0] load_val_a = '0;
  logic signed [16:0] load_val_b = '0;

  logic signed [15:0] pos_a;
  logic               at_min_a, at_max_a, vel_valid_a, dir_err_a;
  logic signed [7:0]  vel_a;

  logic signed [16:0] pos_b;
  logic               at_min_b, at_max_b, vel_valid_b, dir_err_b;
  logic signed [7:0]  vel_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  encoder_position_tracker #(
    .WIDTH(16), .POS_MIN(-32768), .POS_MAX(32767), .VEL_WIDTH(8), .WINDOW(10)
  ) u_a (
    .clk(clk), .rst(rst), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val_a), .position(pos_a), .at_min(at_min_a), .at_max(at_max_a),
    .velocity(vel_a), .vel_valid(vel_valid_a), .dir_err(dir_err_a)
  );

  encoder_position_tracker #(
    .WIDTH(17), .POS_MIN(-32768), .POS_MAX(32767), .VEL_WIDTH(8), .WINDOW(256)
  ) u_b (
    .clk(clk), .rst(rst), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val_b), .position(pos_b), .at_min(at_min_b), .at_max(at_max_b),
    .velocity(vel_b), .vel_valid(vel_valid_b), .dir_err(dir_err_b)
  );

  typedef struct {
    logic [1:0] dir;
    logic       clr;
    logic       ld;
    int         lv;
    int         pos;
    logic       amin;
    logic       amax;
    logic       err;
  } vec_t;

  vec_t tbl[23];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dir = 2'b00; clear = 1'b0; load = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    //            dir    clr ld  load_val pos     min max err
    tbl[0]  = '{2'b01, 0, 0, 0,      1,      0, 0, 0};
    tbl[1]  = '{2'b01, 0, 0, 0,      2,      0, 0, 0};
    tbl[2]  = '{2'b01, 0, 0, 0,      3,      0, 0, 0};
    tbl[3]  = '{2'b01, 0, 0, 0,      4,      0, 0, 0};
    tbl[4]  = '{2'b01, 0, 0, 0,      5,      0, 0, 0};
    tbl[5]  = '{2'b10, 0, 0, 0,      4,      0, 0, 0};
    tbl[6]  = '{2'b10, 0, 0, 0,      3,      0, 0, 0};
    tbl[7]  = '{2'b00, 0, 1, 32766,  32766,  0, 0, 0};
    tbl[8]  = '{2'b01, 0, 0, 0,      32767,  0, 1, 0};
    tbl[9]  = '{2'b01, 0, 0, 0,      32767,  0, 1, 0};
    tbl[10] = '{2'b01, 0, 0, 0,      32767,  0, 1, 0};
    tbl[11] = '{2'b10, 0, 0, 0,      32766,  0, 0, 0};
    tbl[12] = '{2'b00, 0, 1, -32767, -32767, 0, 0, 0};
    tbl[13] = '{2'b10, 0, 0, 0,      -32768, 1, 0, 0};
    tbl[14] = '{2'b10, 0, 0, 0,      -32768, 1, 0, 0};
    tbl[15] = '{2'b11, 0, 0, 0,      -32768, 1, 0, 1};
    tbl[16] = '{2'b00, 0, 0, 0,      -32768, 1, 0, 1};
    tbl[17] = '{2'b01, 0, 0, 0,      -32767, 0, 0, 1};
    tbl[18] = '{2'b11, 1, 0, 0,      0,      0, 0, 0};
    tbl[19] = '{2'b01, 0, 1, 100,    100,    0, 0, 0};
    tbl[20] = '{2'b00, 1, 1, 500,    0,      0, 0, 0};
    tbl[21] = '{2'b11, 0, 0, 0,      0,      0, 0, 1};
    tbl[22] = '{2'b00, 0, 0, 0,      0,      0, 0, 1};

    // Reset state
    do_reset();
    chk("reset_pos", int'(pos_a), 0);
    chk("reset_vel", int'(vel_a), 0);
    chk("reset_vel_valid", int'(vel_valid_a), 0);
    chk("reset_dir_err", int'(dir_err_a), 0);
    chk("reset_at_min", int'(at_min_a), 0);
    chk("reset_at_max", int'(at_max_a), 0);
    $display("reset: pos=%0d vel=%0d err=%0d", pos_a, vel_a, dir_err_a);

    // Position / flag table
    for (int i = 0; i < 23; i++) begin
      dir = tbl[i].dir; clear = tbl[i].clr; load = tbl[i].ld;
      load_val_a = 16'(tbl[i].lv);
      tick();
      $display("vec %0d: dir=%b clr=%0d ld=%0d -> pos=%0d min=%0d max=%0d err=%0d",
               i, tbl[i].dir, tbl[i].clr, tbl[i].ld, pos_a, at_min_a, at_max_a, dir_err_a);
      chk($sformatf("vec%0d_pos", i), int'(pos_a), tbl[i].pos);
      chk($sformatf("vec%0d_at_min", i), int'(at_min_a), int'(tbl[i].amin));
      chk($sformatf("vec%0d_at_max", i), int'(at_max_a), int'(tbl[i].amax));
      chk($sformatf("vec%0d_dir_err", i), int'(dir_err_a), int'(tbl[i].err));
    end
    clear = 1'b0; load = 1'b0; dir = 2'b00;

    // Velocity: 7 CW then 3 CCW in a 10-cycle window -> +4 at edge 10
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      dir = (i <= 7) ? 2'b01 : 2'b10;
      tick();
      if (i == 9) chk("win1_valid_early", int'(vel_valid_a), 0);
    end
    $display("window 7CW/3CCW: vel_valid=%0d velocity=%0d", vel_valid_a, vel_a);
    chk("win1_valid", int'(vel_valid_a), 1);
    chk("win1_velocity", int'(vel_a), 4);
    dir = 2'b00;
    tick();
    chk("win1_valid_pulse", int'(vel_valid_a), 0);
    chk("win1_vel_hold", int'(vel_a), 4);

    // Step coinciding with clear: dropped from position, counted in velocity
    do_reset();
    dir = 2'b01; clear = 1'b1;
    tick();
    $display("step+clear: pos=%0d", pos_a);
    chk("clr_step_pos", int'(pos_a), 0);
    dir = 2'b00; clear = 1'b0;
    for (int i = 2; i <= 10; i++) tick();
    $display("step+clear window: vel_valid=%0d velocity=%0d", vel_valid_a, vel_a);
    chk("clr_step_valid", int'(vel_valid_a), 1);
    chk("clr_step_vel", int'(vel_a), 1);

    // Reset mid-window discards the partial window
    dir = 2'b01;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    chk("midrst_vel", int'(vel_a), 0);
    chk("midrst_pos", int'(pos_a), 0);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      dir = (i <= 2) ? 2'b01 : 2'b00;
      tick();
      if (i == 9) chk("midrst_valid_early", int'(vel_valid_a), 0);
    end
    $display("after mid reset: vel_valid=%0d velocity=%0d", vel_valid_a, vel_a);
    chk("midrst_valid", int'(vel_valid_a), 1);
    chk("midrst_velocity", int'(vel_a), 2);
    dir = 2'b00;

    // Load clamp on 17-bit instance
    do_reset();
    load = 1'b1; load_val_b = -17'sd40000;
    tick();
    $display("load -40000: pos_b=%0d at_min_b=%0d", pos_b, at_min_b);
    chk("clamp_lo_pos", int'(pos_b), -32768);
    chk("clamp_lo_at_min", int'(at_min_b), 1);
    load = 1'b0; dir = 2'b10;
    tick();
    chk("clamp_lo_hold", int'(pos_b), -32768);
    load = 1'b1; load_val_b = 17'sd40000; dir = 2'b00;
    tick();
    $display("load 40000: pos_b=%0d at_max_b=%0d", pos_b, at_max_b);
    chk("clamp_hi_pos", int'(pos_b), 32767);
    chk("clamp_hi_at_max", int'(at_max_b), 1);
    load = 1'b0;

    // Velocity saturation: 200 CW steps in a 256-cycle window -> 127
    do_reset();
    for (int i = 1; i <= 256; i++) begin
      dir = (i <= 200) ? 2'b01 : 2'b00;
      tick();
      if (i == 255) chk("sat_valid_early", int'(vel_valid_b), 0);
    end
    $display("200 CW in 256: vel_valid_b=%0d velocity_b=%0d pos_b=%0d", vel_valid_b, vel_b, pos_b);
    chk("sat_valid", int'(vel_valid_b), 1);
    chk("sat_velocity", int'(vel_b), 127);
    chk("sat_pos_b", int'(pos_b), 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
